// File: rtl/pyfive_wb_arbiter_if.sv
// One Wishbone classic link. The master drives the request and the slave returns ack/data.
interface pyfive_wb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic [DW-1:0]   dat_r;

    modport master (output cyc, stb, we, adr, dat_w, sel, input  ack, dat_r);
    modport slave  (input  cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/pyfive_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of the pyfive_top slave port.
// A watchdog terminates any grant that the target leaves unacknowledged for too long.
module pyfive_wb_arbiter #(
    parameter int            AW             = 32,
    parameter int            DW             = 32,
    parameter int            TIMEOUT_CYCLES = 256,
    parameter logic [DW-1:0] TIMEOUT_DATA   = DW'(32'hDEAD_BEEF)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    pyfive_wb_arbiter_if.slave    m0,
    pyfive_wb_arbiter_if.slave    m1,
    pyfive_wb_arbiter_if.master   s,
    output logic                  timeout_o,
    output logic [7:0]            timeout_cnt_o,
    output logic [1:0]            grant_o
);
    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    state_t          state, state_nxt;
    logic            last, last_nxt;
    logic [CW-1:0]   tmo_cnt;
    logic            req0, req1, gsel;
    logic            g_cyc, g_stb, g_we;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [DW/8-1:0] g_sel;
    logic            fwd_ack;
    logic [DW-1:0]   fwd_dat;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

    // gsel picks the granted master's view; it is only consumed in GNT0/GNT1
    assign gsel  = (state == GNT1);
    assign g_cyc = gsel ? m1.cyc   : m0.cyc;
    assign g_stb = gsel ? m1.stb   : m0.stb;
    assign g_we  = gsel ? m1.we    : m0.we;
    assign g_adr = gsel ? m1.adr   : m0.adr;
    assign g_dat = gsel ? m1.dat_w : m0.dat_w;
    assign g_sel = gsel ? m1.sel   : m0.sel;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        timeout_o = 1'b0;
        fwd_ack   = 1'b0;
        fwd_dat   = '0;
        s.cyc     = 1'b0;
        s.stb     = 1'b0;
        s.we      = 1'b0;
        s.adr     = '0;
        s.dat_w   = '0;
        s.sel     = '0;
        unique case (state)
            IDLE: begin
                if (req0 && (!req1 || last)) state_nxt = GNT0;
                else if (req1)               state_nxt = GNT1;
            end
            default: begin
                s.cyc   = g_cyc;
                s.stb   = g_stb;
                s.we    = g_we;
                s.adr   = g_adr;
                s.dat_w = g_dat;
                s.sel   = g_sel;
                fwd_ack = s.ack;
                fwd_dat = s.dat_r;
                if (!g_cyc) begin
                    // abort wins over a coincident target ack
                    fwd_ack   = 1'b0;
                    state_nxt = IDLE;
                    last_nxt  = gsel;
                end else if (s.ack) begin
                    state_nxt = IDLE;
                    last_nxt  = gsel;
                end else if (tmo_cnt == TMO_LAST) begin
                    fwd_ack   = 1'b1;
                    fwd_dat   = TIMEOUT_DATA;
                    s.cyc     = 1'b0;
                    s.stb     = 1'b0;
                    timeout_o = 1'b1;
                    state_nxt = IDLE;
                    last_nxt  = gsel;
                end
            end
        endcase
    end

    assign m0.ack   = (state == GNT0) & fwd_ack;
    assign m1.ack   = (state == GNT1) & fwd_ack;
    assign m0.dat_r = (state == GNT0) ? fwd_dat : '0;
    assign m1.dat_r = (state == GNT1) ? fwd_dat : '0;
    assign grant_o  = state;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // every grant exits through IDLE, so clearing there covers entry into GNTn
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt       <= '0;
            timeout_cnt_o <= '0;
        end else begin
            tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + CW'(1);
            if (timeout_o && timeout_cnt_o != 8'hFF)
                timeout_cnt_o <= timeout_cnt_o + 8'd1;
        end
    end
endmodule

// File: tb/tb_pyfive_wb_arbiter.sv
// Bench for pyfive_wb_arbiter: vector table plus hand sequences, acks checked against a scoreboard.
module tb_pyfive_wb_arbiter;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       timeout_o;
    logic [7:0] tcnt;
    logic [1:0] grant_o;

    pyfive_wb_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    pyfive_wb_arbiter_if #(.AW(32), .DW(32)) m1_if ();
    pyfive_wb_arbiter_if #(.AW(32), .DW(32)) s_if ();

    pyfive_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
        .timeout_o(timeout_o), .timeout_cnt_o(tcnt), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m; logic we; logic [31:0] adr, wdat; logic [3:0] sel;
        int dly; logic [31:0] rdata, exp_dat; bit exp_tmo;
    } vec_t;

    typedef struct {
        int m; bit tmo; logic [31:0] dat; logic we; logic [31:0] adr, wdat;
        logic [3:0] sel; int cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          alt_exp[6] = '{0, 1, 0, 2, 0, 1};
    int          n_checks = 0, n_errors = 0;
    int          cyc_cnt = 0, gcyc = 0, exp_tcnt = 0;
    int          tgt_delay = -1;
    logic        tgt_force = 1'b0;
    logic [31:0] tgt_rdata = '0;

    // target model: acks on granted-cycle index tgt_delay, counted from the registered grant
    assign s_if.ack   = tgt_force | ((grant_o != 2'b00) && (gcyc == tgt_delay));
    assign s_if.dat_r = tgt_rdata;

    always @(posedge clk) cyc_cnt++;
    always @(posedge clk or posedge rst)
        if (rst) gcyc <= 0;
        else     gcyc <= (grant_o != 2'b00) ? gcyc + 1 : 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // scoreboard consumer: every master ack must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        int   m;
        if (m0_if.ack || m1_if.ack) begin
            if (sb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b with empty scoreboard", m0_if.ack, m1_if.ack);
            end else begin
                e = sb.pop_front();
                m = m1_if.ack ? 1 : 0;
                chk("ack_master", m, e.m);
                chk("ack_both", m0_if.ack & m1_if.ack, 0);
                chk("ack_cycle", cyc_cnt, e.cyc);
                chk("ack_dat", m ? m1_if.dat_r : m0_if.dat_r, e.dat);
                chk("other_dat", m ? m0_if.dat_r : m1_if.dat_r, 0);
                chk("ack_grant", grant_o, (e.m == 1) ? 2 : 1);
                chk("ack_timeout_o", timeout_o, e.tmo);
                chk("ack_s_cyc", s_if.cyc, !e.tmo);
                chk("ack_tcnt", tcnt, exp_tcnt);
                if (e.tmo) exp_tcnt++;
                else begin
                    chk("s_we", s_if.we, e.we);
                    chk("s_adr", s_if.adr, e.adr);
                    chk("s_dat", s_if.dat_w, e.wdat);
                    chk("s_sel", s_if.sel, e.sel);
                end
            end
        end else if (timeout_o) begin
            n_checks++; n_errors++;
            $display("FAIL spurious_timeout: timeout_o=1 without master ack");
        end
    end

    task automatic drive(input int m, input logic c, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel);
        if (m == 0) begin
            m0_if.cyc = c; m0_if.stb = c; m0_if.we = we; m0_if.adr = adr; m0_if.dat_w = wd; m0_if.sel = sel;
        end else begin
            m1_if.cyc = c; m1_if.stb = c; m1_if.we = we; m1_if.adr = adr; m1_if.dat_w = wd; m1_if.sel = sel;
        end
    endtask

    task automatic push(input int m, input bit tmo, input logic [31:0] dat, input logic we,
                        input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel, input int cyc);
        exp_t e;
        e.m = m; e.tmo = tmo; e.dat = dat; e.we = we; e.adr = adr; e.wdat = wd; e.sel = sel; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // called and returns at posedge+1
    task automatic wait_drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d expected acks never arrived", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_s_cyc"}, s_if.cyc, 0);
        chk({tag, "_s_adr"}, s_if.adr, 0);
        chk({tag, "_acks"}, {m0_if.ack, m1_if.ack}, 0);
        chk({tag, "_tcnt"}, tcnt, exp_tcnt);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF,  2, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF,  0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{0, 1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, -1, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1, 1'b1, 32'h3000_0030, 32'h55AA_55AA, 4'h3,  7, 32'h2222_3333, 32'h2222_3333, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h3000_0040, 32'h0000_0000, 4'hC, -1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{0, 1'b0, 32'h3000_0050, 32'h0000_0000, 4'h1,  5, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};

        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_s_cyc", s_if.cyc, 0);
        chk("rst_acks", {m0_if.ack, m1_if.ack}, 0);
        chk("rst_timeout_o", timeout_o, 0);
        chk("rst_tcnt", tcnt, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // simultaneous requests held: m0, m1, m0 with an idle cycle between grants
        tgt_delay = 0; tgt_rdata = 32'h0BAD_0001;
        drive(0, 1, 0, 32'h3000_0100, 32'h0, 4'hF);
        drive(1, 1, 0, 32'h3000_0200, 32'h0, 4'hF);
        push(0, 0, 32'h0BAD_0001, 0, 32'h3000_0100, 32'h0, 4'hF, cyc_cnt + 1);
        push(1, 0, 32'h0BAD_0001, 0, 32'h3000_0200, 32'h0, 4'hF, cyc_cnt + 3);
        push(0, 0, 32'h0BAD_0001, 0, 32'h3000_0100, 32'h0, 4'hF, cyc_cnt + 5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("alt_grant", grant_o, alt_exp[k]);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        wait_drain(2);
        idle_check("alt_idle");

        // vector table: single-master transactions incl. timeout and ack-on-timeout-cycle
        for (int i = 0; i < 6; i++) begin
            tgt_delay = vecs[i].dly; tgt_rdata = vecs[i].rdata;
            drive(vecs[i].m, 1, vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel);
            push(vecs[i].m, vecs[i].exp_tmo, vecs[i].exp_dat, vecs[i].we, vecs[i].adr, vecs[i].wdat,
                 vecs[i].sel, cyc_cnt + 1 + (vecs[i].exp_tmo ? T - 1 : vecs[i].dly));
            wait_drain(T + 4);
            drive(vecs[i].m, 0, 0, '0, '0, '0);
            idle_check("vec_idle");
        end

        // m1 aborts after 3 granted cycles with a coincident target ack; pending m0 follows
        tgt_delay = -1; tgt_rdata = 32'h7777_0000;
        drive(1, 1, 0, 32'h3000_0300, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive(0, 1, 1, 32'h3000_0400, 32'h0102_0304, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        m1_if.cyc = 1'b0; tgt_force = 1'b1;
        @(negedge clk);
        chk("abort_m1_ack", m1_if.ack, 0);
        chk("abort_grant", grant_o, 2);
        @(posedge clk); #1;
        tgt_force = 1'b0; tgt_delay = 0;
        push(0, 0, 32'h7777_0000, 1, 32'h3000_0400, 32'h0102_0304, 4'hF, cyc_cnt + 1);
        @(negedge clk);
        chk("abort_idle_grant", grant_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_next_grant", grant_o, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        wait_drain(2);
        idle_check("abort_idle");

        // asynchronous reset in the middle of a GNT0 cycle
        tgt_delay = -1;
        drive(0, 1, 0, 32'h3000_0500, 32'h0, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_pre_grant", grant_o, 1);
        chk("mid_pre_tcnt", tcnt, exp_tcnt);
        rst = 1'b1;
        #1;
        exp_tcnt = 0;
        chk("mid_rst_s_cyc", s_if.cyc, 0);
        chk("mid_rst_grant", grant_o, 0);
        chk("mid_rst_tcnt", tcnt, 0);
        chk("mid_rst_ack", m0_if.ack, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        drive(0, 0, 0, '0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tgt_delay = 0; tgt_rdata = 32'h0000_0042;
        drive(0, 1, 0, 32'h3000_0600, 32'h0, 4'hF);
        drive(1, 1, 0, 32'h3000_0700, 32'h0, 4'hF);
        push(0, 0, 32'h0000_0042, 0, 32'h3000_0600, 32'h0, 4'hF, cyc_cnt + 1);
        wait_drain(4);
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        idle_check("post_rst_idle");

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pyfive_wb_arbiter.md
Name: pyfive_wb_arbiter

Overview:
- Two-master, one-target Wishbone classic arbiter in front of the pyfive_top Wishbone slave port.
- Master 0 is the Caravel management bus (wbs_*); master 1 is an internal debug/DMA master.
- Arbitration is round-robin with a per-transaction timeout watchdog, so a hung target cannot lock either master.
- Sits in the user area between the wrapper Wishbone pins and pyfive_top.

Parameters:
- AW, 32, address width
- DW, 32, data width; SEL width is DW/8
- TIMEOUT_CYCLES, 256, cycles in a granted state without target ack before forced termination (minimum 2)
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out cycle

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus controls
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_sel_i  in  DW/8  master 0 byte selects
- m0_ack_o  out  1  master 0 acknowledge
- m0_dat_o  out  DW  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  target bus controls
- s_adr_o  out  AW  target address
- s_dat_o  out  DW  target write data
- s_sel_o  out  DW/8  target byte selects
- s_ack_i  in  1  target acknowledge
- s_dat_i  in  DW  target read data
- timeout_o  out  1  one-cycle pulse on forced termination
- timeout_cnt_o  out  8  saturating count of timeouts
- grant_o  out  2  one-hot current grant, {m1,m0}; 00 when idle

Behaviour:
- State machine: IDLE, GNT0, GNT1, all registered. The last-granted bit (last) resets to 1, so m0 wins the first tie.
- Request definition: req_n = mN_cyc_i & mN_stb_i.
- IDLE transitions:
  - Only req0 → GNT0.
  - Only req1 → GNT1.
  - Both → grant the master other than last.
  - Neither → stay in IDLE.
  - Grant is taken at the next clock edge: 1 cycle of arbitration latency.
- GNTn, target side: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o are combinationally routed from master n.
- GNTn, master side: mN_ack_o = s_ack_i and mN_dat_o = s_dat_i, combinationally, with zero added latency.
- Non-granted master: ack_o=0, dat_o=0.
- IDLE outputs: all s_* outputs = 0.
- GNTn exit on s_ack_i=1: next state IDLE, last←n. Each transaction is followed by one mandatory idle cycle, so back-to-back pipelining across masters is not supported.
- GNTn exit on mN_cyc_i=0 before ack (abort): next state IDLE, last←n, no ack issued. s_ack_i arriving in the same cycle is ignored.
- Timeout counter:
  - Cleared on entry to GNTn; increments each cycle in GNTn.
  - When it equals TIMEOUT_CYCLES-1 and s_ack_i=0 in that cycle, the arbiter:
    - drives mN_ack_o=1 with mN_dat_o=TIMEOUT_DATA;
    - forces s_cyc_o=s_stb_o=0 in that cycle;
    - pulses timeout_o=1;
    - increments timeout_cnt_o, saturating at 255;
    - next state IDLE, last←n.
- Ack on the timeout cycle: if s_ack_i=1 in that same cycle, it is a normal ack with no timeout.
- Counter sizing: the counter width is clog2(TIMEOUT_CYCLES), and it must never wrap within one grant.
- grant_o equals the one-hot state encoding (GNT0→01, GNT1→10, IDLE→00).
- Reset, asynchronous and taking effect mid-transaction: state=IDLE, last=1, timeout counter=0, timeout_cnt_o=0. All outputs then read 0: timeout_o=0, all ack_o=0, all s_* outputs=0.
- An in-flight target cycle is dropped on reset. Masters must restart the transaction.
- Master compliance: masters hold cyc/stb/adr/dat/sel stable until ack. A stb change while granted is passed through unchecked.

Test Plan:
- m0 write adr=0x3000_0004 dat=0x1234_5678 sel=F, target acks 2 cycles after grant → s_* mirrors m0, m0_ack_o high exactly 1 cycle, grant_o=01 then 00, m1_ack_o stays 0.
- m0 and m1 request in the same cycle after reset → m0 granted first. With both holding requests, grants alternate GNT0, GNT1, GNT0 with one IDLE cycle between each.
- m1 read, target returns s_dat_i=0xCAFE_F00D with ack → m1_dat_o=0xCAFE_F00D on the ack cycle, m0_dat_o=0.
- m0 read, target never acks, TIMEOUT_CYCLES=8 → ack on the 8th granted cycle with m0_dat_o=0xDEAD_BEEF, timeout_o 1-cycle pulse, timeout_cnt_o=1, s_cyc_o low in that cycle.
- m1 granted and drops cyc after 3 cycles → IDLE next cycle, no m1_ack_o, and a pending m0 is granted on the following edge.
- wb_rst_i asserted mid-GNT0 (asynchronously, between edges) → s_cyc_o, grant_o and timeout_cnt_o read 0 immediately. After release, a simultaneous request grants m0 first.
